// File: rtl/keypad_unshuffler_if.sv
// Keypad unshuffler bus: permutation load stream, key presses and decode results.
interface keypad_unshuffler_if #(
  parameter int KEY_W = 4
);
  logic             load_start;
  logic             prn_valid;
  logic [KEY_W-1:0] prn4;
  logic             key_valid;
  logic [KEY_W-1:0] key_pos;
  logic [KEY_W-1:0] digit;
  logic             digit_valid;
  logic             key_err;
  logic             table_ready;
  logic             table_error;
  logic             busy;

  modport master (
    output load_start, prn_valid, prn4, key_valid, key_pos,
    input  digit, digit_valid, key_err, table_ready, table_error, busy
  );

  modport slave (
    input  load_start, prn_valid, prn4, key_valid, key_pos,
    output digit, digit_valid, key_err, table_ready, table_error, busy
  );
endinterface

// File: rtl/keypad_unshuffler.sv
// Captures a key-label permutation, validates it, then maps physical key positions to logical digits.
// Decode latency 1 clock; no backpressure, every press yields exactly one digit_valid or key_err pulse.
module keypad_unshuffler #(
  parameter int NUM_KEYS = 10,
  parameter int KEY_W    = 4
) (
  input logic                clk,
  input logic                rstn,
  keypad_unshuffler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_KEYS + 1);
  localparam logic [KEY_W:0]   NK   = (KEY_W + 1)'(NUM_KEYS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_KEYS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READY, ERROR} state_t;

  state_t              state, nxt;
  logic [KEY_W-1:0]    key_table [NUM_KEYS];
  logic [NUM_KEYS-1:0] used;
  logic [IDX_W-1:0]    idx;
  logic [KEY_W-1:0]    digit;
  logic                digit_valid, key_err;

  logic prn_ok, key_ok, wr_en, dec_en, err_en;

  // Range check first so an out-of-range label never relies on the used-mask lookup.
  assign prn_ok = ({1'b0, bus.prn4} < NK) && !used[bus.prn4];
  assign key_ok = ({1'b0, bus.key_pos} < NK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt    = state;
    wr_en  = 1'b0;
    dec_en = 1'b0;
    err_en = 1'b0;
    if (bus.load_start) begin
      nxt = LOAD;
    end else begin
      case (state)
        LOAD: begin
          err_en = bus.key_valid;
          if (bus.prn_valid) begin
            if (!prn_ok) begin
              nxt = ERROR;
            end else begin
              wr_en = 1'b1;
              if (idx == LAST) nxt = READY;
            end
          end
        end
        READY: begin
          if (bus.key_valid) begin
            dec_en = key_ok;
            err_en = !key_ok;
          end
        end
        default: err_en = bus.key_valid;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_KEYS; i++) key_table[i] <= '0;
      used        <= '0;
      idx         <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      key_err     <= 1'b0;
    end else begin
      digit_valid <= dec_en;
      key_err     <= err_en;
      if (dec_en) digit <= key_table[bus.key_pos];
      if (bus.load_start) begin
        for (int i = 0; i < NUM_KEYS; i++) key_table[i] <= '0;
        used <= '0;
        idx  <= '0;
      end else if (wr_en) begin
        key_table[idx]  <= bus.prn4;
        used[bus.prn4]  <= 1'b1;
        idx             <= idx + 1'b1;
      end
    end
  end

  assign bus.digit       = digit;
  assign bus.digit_valid = digit_valid;
  assign bus.key_err     = key_err;
  assign bus.table_ready = (state == READY);
  assign bus.table_error = (state == ERROR);
  assign bus.busy        = (state == LOAD);
endmodule

// File: tb/tb_keypad_unshuffler.sv
// Directed bench for keypad_unshuffler: load, validation, decode and reset scenarios.
module tb_keypad_unshuffler;
  logic clk = 1'b0;
  logic rstn;
  int   compared = 0;
  int   mismatched = 0;

  keypad_unshuffler_if #(.KEY_W(4)) bus ();

  keypad_unshuffler #(.NUM_KEYS(10), .KEY_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic dv, input logic ke,
                             input logic rdy, input logic te, input logic bsy);
    check({tag, ".digit_valid"}, 32'(bus.digit_valid), 32'(dv));
    check({tag, ".key_err"},     32'(bus.key_err),     32'(ke));
    check({tag, ".table_ready"}, 32'(bus.table_ready), 32'(rdy));
    check({tag, ".table_error"}, 32'(bus.table_error), 32'(te));
    check({tag, ".busy"},        32'(bus.busy),        32'(bsy));
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic push(input logic [3:0] v);
    bus.prn_valid = 1'b1;
    bus.prn4      = v;
    tick();
    bus.prn_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] p);
    bus.key_valid = 1'b1;
    bus.key_pos   = p;
    tick();
    bus.key_valid = 1'b0;
  endtask

  logic [3:0] perm_a [10] = '{4'd3, 4'd7, 4'd0, 4'd9, 4'd1, 4'd5, 4'd2, 4'd8, 4'd6, 4'd4};

  initial begin
    rstn           = 1'b0;
    bus.load_start = 1'b0;
    bus.prn_valid  = 1'b0;
    bus.prn4       = '0;
    bus.key_valid  = 1'b0;
    bus.key_pos    = '0;
    tick();
    tick();
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.digit", 32'(bus.digit), 32'd0);
    rstn = 1'b1;
    tick();

    // 1: basic load of a scrambled permutation and two decodes
    start_load();
    check("t1.busy_after_start", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      push(perm_a[i]);
      check($sformatf("t1.ready_slot%0d", i), 32'(bus.table_ready), 32'(i == 9));
      check($sformatf("t1.busy_slot%0d", i),  32'(bus.busy),        32'(i != 9));
    end
    press(4'd0);
    check_flags("t1.p0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t1.p0.digit", 32'(bus.digit), 32'd3);
    tick();
    check("t1.p0.pulse_end", 32'(bus.digit_valid), 32'd0);
    check("t1.p0.held", 32'(bus.digit), 32'd3);
    press(4'd9);
    check("t1.p9.dv", 32'(bus.digit_valid), 32'd1);
    check("t1.p9.digit", 32'(bus.digit), 32'd4);

    // 2: identity load with gaps, key press during load
    start_load();
    press(4'd2);
    check_flags("t2.key_in_load", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      push(4'(i));
      tick();
      check($sformatf("t2.ready_after%0d", i), 32'(bus.table_ready), 32'(i == 9));
    end
    press(4'd5);
    check("t2.p5.dv", 32'(bus.digit_valid), 32'd1);
    check("t2.p5.digit", 32'(bus.digit), 32'd5);

    // 3: duplicate label aborts the capture
    start_load();
    push(4'd2);
    push(4'd5);
    push(4'd2);
    check_flags("t3.dup", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    press(4'd1);
    check_flags("t3.key_in_err", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t3.digit_held", 32'(bus.digit), 32'd5);
    start_load();
    check("t3.err_cleared", 32'(bus.table_error), 32'd0);
    for (int i = 0; i < 10; i++) push(4'(9 - i));
    check_flags("t3.reload", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    press(4'd0);
    check("t3.p0.digit", 32'(bus.digit), 32'd9);

    // 4: out-of-range label in slot 4, trailing entries ignored
    start_load();
    for (int i = 0; i < 4; i++) push(4'(i));
    push(4'd12);
    check_flags("t4.range", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 4; i < 10; i++) push(4'(i));
    check_flags("t4.ignored", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    press(4'd3);
    check("t4.key_err", 32'(bus.key_err), 32'd1);

    // 5: back-to-back presses including an out-of-range position
    start_load();
    for (int i = 0; i < 10; i++) push(perm_a[i]);
    bus.key_valid = 1'b1;
    bus.key_pos   = 4'd1;
    tick();
    check_flags("t5.a", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5.a.digit", 32'(bus.digit), 32'd7);
    tick();
    check_flags("t5.b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5.b.digit", 32'(bus.digit), 32'd7);
    bus.key_pos = 4'd11;
    tick();
    check_flags("t5.c", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5.c.digit_held", 32'(bus.digit), 32'd7);
    bus.key_pos = 4'd4;
    tick();
    bus.key_valid = 1'b0;
    check_flags("t5.d", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5.d.digit", 32'(bus.digit), 32'd1);
    tick();
    check_flags("t5.idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 6: asynchronous reset mid-load
    start_load();
    for (int i = 0; i < 5; i++) push(4'(i));
    check("t6.busy", 32'(bus.busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_flags("t6.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6.digit", 32'(bus.digit), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    press(4'd2);
    check_flags("t6.idle_key", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    start_load();
    for (int i = 0; i < 10; i++) push(4'(i));
    check("t6.ready", 32'(bus.table_ready), 32'd1);
    press(4'd3);
    check("t6.p3.dv", 32'(bus.digit_valid), 32'd1);
    check("t6.p3.digit", 32'(bus.digit), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/keypad_unshuffler.md
Name: keypad_unshuffler

Overview:
- Receiving end of the random keypad shuffler.
- Captures one permutation of key labels, streamed one 4-bit value per valid cycle, into an internal table and checks that it is a true permutation of 0..NUM_KEYS-1.
- Translates physical key positions pressed by the user back into logical digits for the door-lock PIN path.
- Sits between the shuffler output and the PIN entry/compare logic.

Parameters:
- NUM_KEYS, 10, number of keypad positions and table entries (2..16).
- KEY_W, 4, width of label, position and digit values.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rstn  input  1  asynchronous active-low reset.
- load_start  input  1  one-cycle pulse; clears table and starts a capture.
- prn_valid  input  1  prn4 carries a table entry this cycle.
- prn4  input  KEY_W  label for the next table slot (slot 0 first).
- key_valid  input  1  key_pos carries a press this cycle.
- key_pos  input  KEY_W  physical position pressed.
- digit  output  KEY_W  logical digit of last accepted press.
- digit_valid  output  1  one-cycle pulse, digit is new.
- key_err  output  1  one-cycle pulse, press rejected.
- table_ready  output  1  table is a valid permutation; decoding enabled.
- table_error  output  1  last capture failed; sticky until load_start.
- busy  output  1  capture in progress.

Behaviour:
- Reset (rstn=0, asynchronous):
  - State IDLE; all outputs 0.
  - Table entries 0, used-mask 0, slot index 0.
- States: IDLE, LOAD, READY, ERROR.
- load_start in any state:
  - Next state LOAD.
  - Index 0, used-mask 0, table_ready 0, table_error 0.
  - Any same-cycle prn_valid or key_valid is ignored.
- LOAD (busy=1):
  - Each cycle with prn_valid=1, check prn4 against the used-mask.
  - If prn4 >= NUM_KEYS or used[prn4] is already set: next state ERROR, table_error=1.
  - Otherwise: table[index]<=prn4, used[prn4]<=1, index<=index+1.
  - When the write lands in slot NUM_KEYS-1: next state READY, table_ready=1 from the following cycle.
  - Cycles with prn_valid=0 hold state; there is no timeout.
  - key_valid in LOAD produces a key_err pulse.
- READY:
  - key_valid=1 and key_pos < NUM_KEYS: next cycle digit<=table[key_pos] and digit_valid=1 for exactly one cycle. Latency 1 clock.
  - key_valid=1 and key_pos >= NUM_KEYS: next cycle key_err=1 for one cycle; digit unchanged.
  - Back-to-back presses give back-to-back pulses; no throughput limit.
  - prn_valid is ignored.
- ERROR:
  - table_error=1, table_ready=0, busy=0.
  - Every key_valid produces key_err.
  - Exit only via load_start or reset.
- IDLE:
  - key_valid produces key_err; prn_valid is ignored.
- digit holds its last value between pulses; it is cleared only by reset.
- digit_valid and key_err are never high in the same cycle.
- Reset asserted mid-LOAD or mid-READY: immediate return to reset values; no partial table survives.
- Index width is ceil(log2(NUM_KEYS+1)); it never exceeds NUM_KEYS.
- Used-mask width is NUM_KEYS.

Test Plan:
1. Reset, load_start, then stream 3,7,0,9,1,5,2,8,6,4 with prn_valid → busy high for 10 valid cycles, then table_ready=1. Press pos 0 → digit=3; pos 9 → digit=4; each digit_valid is a 1-cycle pulse one clock after key_valid.
2. Load 0..9 with prn_valid toggled every other cycle → table_ready only after the 10th valid. key_valid during load → key_err pulse, digit_valid stays 0.
3. Load 2,5,2 → table_error=1 on the cycle after the second 2 and table_ready=0. Following key_valid → key_err. load_start then a valid permutation → table_error cleared, table_ready=1.
4. Load with entry 12 (>= NUM_KEYS) in slot 4 → ERROR. Remaining prn_valid cycles ignored, table unchanged.
5. In READY, presses at pos 1,1,11,4 on consecutive cycles → digit_valid, digit_valid, key_err, digit_valid pulses on consecutive cycles with correct table values. Digit is held through the key_err cycle.
6. rstn low after 5 entries loaded → all outputs 0 asynchronously. After release, key_valid → key_err (IDLE). A fresh load completes normally.
